// File: rtl/vrf_lane_addr_gen_pkg.sv
// Shared configuration, FSM state type and lane element-count helper
// for the per-lane VRF address sequencer.
package vrf_lane_addr_gen_pkg;

    localparam int unsigned DefNrLane       = 2;
    localparam int unsigned DefVLEN         = 1024;
    localparam int unsigned DefVRFWordWidth = 64;
    localparam int unsigned DefNrBank       = 8;
    localparam int unsigned NrVRegs         = 32;
    localparam int unsigned NrVInsn         = 8;
    localparam int unsigned InsnIDWidth     = $clog2(NrVInsn);
    localparam int unsigned LogNrLane       = $clog2(DefNrLane);

    typedef logic [LogNrLane-1:0] lane_id_t;

    typedef enum logic {
        IDLE,
        BUSY
    } state_e;

    // Number of elements owned by lane_id whose global index is below x
    // (elements are striped round-robin across lanes).
    function automatic logic [31:0] GetLaneEleCnt(
        input logic [31:0] x,
        input logic [31:0] lane_id,
        input logic [31:0] log_nr_lane
    );
        logic [31:0] bias;
        bias = (32'd1 << log_nr_lane) - 32'd1 - lane_id;
        return (x + bias) >> log_nr_lane;
    endfunction

endpackage

// File: rtl/vrf_strb_gen.sv
// Byte strobe for one VRF word: byte b is active iff word*WB+b lies in
// the lane byte range [b0,b1).
module vrf_strb_gen
    import vrf_lane_addr_gen_pkg::*;
#(
    parameter  int unsigned VRFWordWidth = DefVRFWordWidth,
    parameter  int unsigned ByteW        = 14,
    localparam int unsigned WordBytes    = VRFWordWidth / 8,
    localparam int unsigned LogWB        = $clog2(WordBytes),
    localparam int unsigned WordW        = ByteW - LogWB
) (
    input  logic [WordW-1:0]     word,
    input  logic [ByteW-1:0]     b0,
    input  logic [ByteW-1:0]     b1,
    output logic [WordBytes-1:0] strb
);

    logic [ByteW-1:0] pos;

    always_comb begin
        strb = '0;
        pos  = '0;
        for (int unsigned b = 0; b < WordBytes; b++) begin
            pos     = {word, LogWB'(b)};
            strb[b] = (pos >= b0) && (pos < b1);
        end
    end

endmodule

// File: rtl/vrf_lane_addr_gen.sv
// Per-lane VRF address sequencer: turns (vreg, vew, vstart, vl) into one
// beat per VRF word touched by this lane, with address, bank and strobe.
module vrf_lane_addr_gen
    import vrf_lane_addr_gen_pkg::*;
#(
    parameter  int unsigned NrLane       = DefNrLane,
    parameter  int unsigned LaneId       = 0,
    parameter  int unsigned VLEN         = DefVLEN,
    parameter  int unsigned VRFWordWidth = DefVRFWordWidth,
    parameter  int unsigned NrBank       = DefNrBank,
    localparam int unsigned VLWidth      = $clog2(VLEN + 1),
    localparam int unsigned RegWords     = VLEN / NrLane / VRFWordWidth,
    localparam int unsigned AddrW        = $clog2(NrVRegs * RegWords),
    localparam int unsigned BankW        = $clog2(NrBank),
    localparam int unsigned StrbW        = VRFWordWidth / 8
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   flush_i,
    input  logic                   req_valid_i,
    output logic                   req_ready_o,
    input  logic [4:0]             req_vreg_i,
    input  logic [1:0]             req_vew_i,
    input  logic [VLWidth-1:0]     req_vl_i,
    input  logic [VLWidth-1:0]     req_vstart_i,
    input  logic [InsnIDWidth-1:0] req_insn_id_i,
    output logic                   beat_valid_o,
    input  logic                   beat_ready_i,
    output logic [AddrW-1:0]       beat_addr_o,
    output logic [BankW-1:0]       beat_bank_o,
    output logic [StrbW-1:0]       beat_strb_o,
    output logic                   beat_last_o,
    output logic [InsnIDWidth-1:0] beat_insn_id_o
);

    localparam int unsigned LaneLog     = $clog2(NrLane);
    localparam int unsigned LogWB       = $clog2(StrbW);
    localparam int unsigned LogRegWords = $clog2(RegWords);
    localparam int unsigned ByteW       = VLWidth + 3;
    localparam int unsigned WordW       = ByteW - LogWB;

    state_e           state;
    logic [WordW-1:0] cur_w, last_w;
    logic [ByteW-1:0] rb0, rb1;
    logic [4:0]       rvreg;

    logic [31:0]      cnt_vs, cnt_vl;
    logic             req_empty;
    logic [ByteW-1:0] req_b0, req_b1;
    logic [WordW-1:0] req_w0, req_w1;

    logic             beat_hs, load;
    logic [WordW-1:0] nxt_w, nxt_last_w;
    logic [ByteW-1:0] nxt_b0, nxt_b1;
    logic [4:0]       nxt_vreg;
    logic [StrbW-1:0] nxt_strb;
    logic [AddrW-1:0] nxt_addr;
    logic [BankW-1:0] nxt_bank;
    logic             nxt_last;

    // Request decode; an empty request collapses to a single zero-strobe
    // beat at word 0 so completion bookkeeping downstream still fires.
    always_comb begin
        cnt_vs    = GetLaneEleCnt(32'(req_vstart_i), LaneId, LaneLog);
        cnt_vl    = GetLaneEleCnt(32'(req_vl_i), LaneId, LaneLog);
        req_empty = (req_vstart_i >= req_vl_i) || (cnt_vs == cnt_vl);
        req_b0    = req_empty ? '0 : ByteW'(cnt_vs << req_vew_i);
        req_b1    = req_empty ? '0 : ByteW'(cnt_vl << req_vew_i);
        req_w0    = req_empty ? '0 : WordW'(req_b0 >> LogWB);
        req_w1    = req_empty ? '0 : WordW'((req_b1 - ByteW'(1)) >> LogWB);
    end

    // The next beat is computed from registered state plus the handshake,
    // then registered, so beat_ready_i never reaches the beat outputs.
    always_comb begin
        beat_hs     = beat_valid_o && beat_ready_i;
        req_ready_o = !flush_i && ((state == IDLE) || (beat_hs && beat_last_o));
        load        = req_valid_i && req_ready_o;
        nxt_w       = load ? req_w0        : cur_w + WordW'(1);
        nxt_last_w  = load ? req_w1        : last_w;
        nxt_b0      = load ? req_b0        : rb0;
        nxt_b1      = load ? req_b1        : rb1;
        nxt_vreg    = load ? req_vreg_i    : rvreg;
        nxt_addr    = AddrW'((32'(nxt_vreg) << LogRegWords) + 32'(nxt_w));
        nxt_bank    = BankW'(32'(nxt_vreg) + 32'(nxt_w));
        nxt_last    = (nxt_w == nxt_last_w);
    end

    vrf_strb_gen #(
        .VRFWordWidth(VRFWordWidth),
        .ByteW       (ByteW)
    ) u_strb_gen (
        .word(nxt_w),
        .b0  (nxt_b0),
        .b1  (nxt_b1),
        .strb(nxt_strb)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state          <= IDLE;
            cur_w          <= '0;
            last_w         <= '0;
            rb0            <= '0;
            rb1            <= '0;
            rvreg          <= '0;
            beat_valid_o   <= 1'b0;
            beat_addr_o    <= '0;
            beat_bank_o    <= '0;
            beat_strb_o    <= '0;
            beat_last_o    <= 1'b0;
            beat_insn_id_o <= '0;
        end else if (flush_i) begin
            state        <= IDLE;
            beat_valid_o <= 1'b0;
        end else if (load) begin
            state          <= BUSY;
            cur_w          <= nxt_w;
            last_w         <= nxt_last_w;
            rb0            <= nxt_b0;
            rb1            <= nxt_b1;
            rvreg          <= nxt_vreg;
            beat_valid_o   <= 1'b1;
            beat_addr_o    <= nxt_addr;
            beat_bank_o    <= nxt_bank;
            beat_strb_o    <= nxt_strb;
            beat_last_o    <= nxt_last;
            beat_insn_id_o <= req_insn_id_i;
        end else if (beat_hs) begin
            if (beat_last_o) begin
                state        <= IDLE;
                beat_valid_o <= 1'b0;
            end else begin
                cur_w       <= nxt_w;
                beat_addr_o <= nxt_addr;
                beat_bank_o <= nxt_bank;
                beat_strb_o <= nxt_strb;
                beat_last_o <= nxt_last;
            end
        end
    end

endmodule

// File: doc/vrf_lane_addr_gen.md
Name: vrf_lane_addr_gen

Overview:
- Per-lane VRF address sequencer that extends the static register-to-address mapping with vstart, vl and element width.
- Accepts one operand or writeback request and emits, in order, one beat per VRF word that the lane touches: address, bank and byte strobe.
- Handles non-aligned head and tail, and register-group crossing.
- One instance sits in each lane ahead of the operand requester and the writeback path; NrLane and LaneId make it generic across lane counts.

Parameters:
- NrLane, 2: lanes in the core; power of 2.
- LaneId, 0: index of this lane, 0..NrLane-1.
- VLEN, 1024: bits per vector register.
- VRFWordWidth, 64: bits per VRF word; power of 2.
- NrBank, 8: VRF banks per lane; power of 2.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- flush_i  in  1  abort the current request
- req_valid_i  in  1  request valid
- req_ready_o  out  1  request accepted when valid&ready
- req_vreg_i  in  5  base register (vreg_t)
- req_vew_i  in  2  element width (VRFEW8..VRFEW64 encoding)
- req_vl_i  in  VLWidth  vl (vlen_t)
- req_vstart_i  in  VLWidth  vstart (vlen_t)
- req_insn_id_i  in  InsnIDWidth  instruction id
- beat_valid_o  out  1  beat valid
- beat_ready_i  in  1  beat consumed when valid&ready
- beat_addr_o  out  $clog2(VRFSliceNumWords)  VRF word address (vrf_addr_t)
- beat_bank_o  out  $clog2(NrBank)  target bank (bank_id_t)
- beat_strb_o  out  VRFWordWidth/8  active byte strobe (vrf_strb_t)
- beat_last_o  out  1  final beat of the request
- beat_insn_id_o  out  InsnIDWidth  id of the owning request

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset values: state IDLE, beat_valid_o=0, req_ready_o=1, all other outputs 0.
- Lane element count:
  - ewB = 1<<vew bytes; WB = VRFWordWidth/8.
  - cnt(x) = (x + NrLane-1-LaneId) >> log2(NrLane), the number of this lane's elements with global index < x.
  - Lane byte range is [B0,B1), with B0 = cnt(vstart)*ewB and B1 = cnt(vl)*ewB.
- Word range: first word w0 = B0/WB, last word w1 = (B1-1)/WB.
- Address: {vreg, zeros(log2 RegSliceNumWords)} + w. Add modulo VRFSliceNumWords, so the address wraps past v31 to v0.
- Bank: (vreg + w) mod NrBank.
- Strobe: byte b of word w is set iff w*WB+b lies in [B0,B1). The head and tail words may be partial; if w0==w1, both masks apply.
- Empty request (vstart >= vl, or B0 == B1): exactly one beat with address of w=0, strb=0 and last=1, so downstream completion bookkeeping still fires.
- State IDLE:
  - req_ready_o=1.
  - On accept, register w0, w1, B0, B1, vreg and insn_id, then go to BUSY.
  - The first beat is valid the next cycle (latency 1).
- State BUSY:
  - beat_valid_o=1. Outputs are stable while beat_ready_i=0, and no combinational path runs from beat_ready_i to the beat outputs.
  - On each handshake, the current word increments.
  - beat_last_o=1 when the current word equals w1.
- Back-to-back requests:
  - req_ready_o is also 1 in BUSY during the cycle the last beat handshakes.
  - A request accepted in that cycle reloads the state, and its first beat is valid the next cycle with no bubble.
  - Otherwise the block returns to IDLE.
- flush_i:
  - Has priority over all handshakes.
  - Next cycle: IDLE, beat_valid_o=0.
  - A request presented in the same cycle as flush_i is not accepted (req_ready_o=0 while flush_i=1).
- Reset mid-operation: identical to flush_i, plus all registers cleared.
- Throughput: one beat per cycle under continuous beat_ready_i.

Decomposition:
- Additions to core_pkg:
  - LogNrLane, RegSliceNumWords and VRFSliceNumWords are already defined there.
  - Add a function GetLaneEleCnt(vlen_t x, lane_id) returning lane_vlen_t.
  - Add typedef lane_id_t = logic [LogNrLane-1:0].
- Sub-module: vrf_strb_gen, combinational, mapping (word index, B0, B1) to a strobe. Reused by the writeback mask path.

Test Plan (NrLane=2, VLEN=1024, VRFWordWidth=64, NrBank=8; RegSliceNumWords=8):
- Aligned: LaneId=0, vreg=3, EW8, vstart=0, vl=32 -> 2 beats: addr 24 bank 3 strb FF; addr 25 bank 4 strb FF last.
- Unaligned, LaneId=1: vreg=0, EW16, vstart=3, vl=21 -> B0=2, B1=20 -> strbs FC, FF, 0F at addr 0, 1, 2; last on the third beat.
- Same request, LaneId=0 -> B0=4, B1=22 -> strbs F0, FF, 3F.
- Empty: vstart=5, vl=5 -> one beat strb 00 last=1, one cycle after accept.
- Group wrap: LaneId=0, vreg=31, EW64, vl=32 -> 16 beats at addr 248..255 then 0..7, banks cycling 7,0,1,...
- Backpressure and flush:
  - Hold beat_ready_i low for 3 cycles mid-stream -> outputs stable.
  - Back-to-back second request -> no idle cycle between last and first.
  - Assert flush_i mid-stream -> beat_valid_o=0 next cycle and req_ready_o=1 after.
